vga_bounce_renderer: RTL

Pixel-generation stage directly downstream of the VGA sync generator. It consumes the sync generator's HS, VS, blank_n, xPos and yPos, and draws one frame per vertical sync:
- a vertical blue gradient background,
- a 1-pixel white border,
- a square red ball that moves each frame and bounces off the screen edges.

It re-times HS, VS and blank_n so they stay aligned with the RGB it produces, and drives the DAC/connector pins.

---
 rtl/vga_bounce_renderer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: draws gradient, border and a bouncing ball behind the VGA sync generator.
// Two-stage pixel pipeline; ball position only changes right after a VS falling edge.
module vga_bounce_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 16,
  parameter int SPEED_X   = 4,
  parameter int SPEED_Y   = 2,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 100
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic        blank_n,
  input  logic [10:0] xPos,
  input  logic [9:0]  yPos,
  input  logic        pause,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [15:0] frame_count
);
  typedef enum logic [1:0] {WAIT, UPD_X, UPD_Y} state_t;
  localparam logic [11:0] XLIM = 12'(H_ACTIVE);
  localparam logic [11:0] XB   = 12'(BALL_SIZE);
  localparam logic [11:0] XS   = 12'(SPEED_X);
  localparam logic [10:0] YLIM = 11'(V_ACTIVE);
  localparam logic [10:0] YB   = 11'(BALL_SIZE);
  localparam logic [10:0] YS   = 11'(SPEED_Y);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  YMAX = 10'(V_ACTIVE - BALL_SIZE);
  state_t      r_state;
  logic [10:0] r_ball_x;
  logic [9:0]  r_ball_y;
  logic        r_dir_x, r_dir_y, r_vs_prev, r_pause;
  logic [15:0] r_frame_count;
  logic        r_hs1, r_vs1, r_bl1, r_ball1, r_bord1;
  logic [7:0]  r_b1;
  logic [23:0] r_rgb;
  logic        r_hs2, r_vs2, r_bl2;
  logic        w_fs, w_pause_l, w_hit_x, w_hit_y, w_border;
  logic [11:0] w_x_fwd;
  logic [10:0] w_y_fwd;
  assign w_fs      = !VS && r_vs_prev;
  assign w_pause_l = w_fs ? pause : r_pause;
  assign w_x_fwd   = {1'b0, r_ball_x} + XB + XS;
  assign w_y_fwd   = {1'b0, r_ball_y} + YB + YS;
  // One bit wider so ball_x+BALL_SIZE cannot wrap at the right/bottom edge.
  assign w_hit_x   = ({1'b0, xPos} >= {1'b0, r_ball_x}) && ({1'b0, xPos} < {1'b0, r_ball_x} + XB);
  assign w_hit_y   = ({1'b0, yPos} >= {1'b0, r_ball_y}) && ({1'b0, yPos} < {1'b0, r_ball_y} + YB);
  assign w_border  = (xPos == 11'd0) || (xPos == 11'(H_ACTIVE - 1)) ||
                     (yPos == 10'd0) || (yPos == 10'(V_ACTIVE - 1));
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state       <= WAIT;
      r_ball_x      <= 11'(INIT_X);
      r_ball_y      <= 10'(INIT_Y);
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b1;
      r_vs_prev     <= 1'b1;
      r_pause       <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_vs_prev <= VS;
      if (w_fs) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_pause       <= pause;
      end
      case (r_state)
        WAIT: if (w_fs && !w_pause_l) r_state <= UPD_X;
        UPD_X: begin
          r_state <= UPD_Y;
          if (r_dir_x) begin
            if (w_x_fwd > XLIM) begin
              r_ball_x <= XMAX;
              r_dir_x  <= 1'b0;
            end else r_ball_x <= r_ball_x + XS[10:0];
          end else if (r_ball_x < XS[10:0]) begin
            r_ball_x <= 11'd0;
            r_dir_x  <= 1'b1;
          end else r_ball_x <= r_ball_x - XS[10:0];
        end
        UPD_Y: begin
          r_state <= WAIT;
          if (r_dir_y) begin
            if (w_y_fwd > YLIM) begin
              r_ball_y <= YMAX;
              r_dir_y  <= 1'b0;
            end else r_ball_y <= r_ball_y + YS[9:0];
          end else if (r_ball_y < YS[9:0]) begin
            r_ball_y <= 10'd0;
            r_dir_y  <= 1'b1;
          end else r_ball_y <= r_ball_y - YS[9:0];
        end
        default: r_state <= WAIT;
      endcase
    end
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      {r_hs1, r_vs1, r_bl1, r_ball1, r_bord1} <= 5'b11000;
      r_b1  <= 8'd0;
      r_rgb <= 24'd0;
      {r_hs2, r_vs2, r_bl2} <= 3'b110;
    end else begin
      {r_hs1, r_vs1, r_bl1} <= {HS, VS, blank_n};
      r_ball1 <= w_hit_x && w_hit_y;
      r_bord1 <= w_border;
      r_b1    <= yPos[8:1];
      r_rgb   <= !r_bl1 ? 24'h000000 : r_ball1 ? 24'hFF0000 : r_bord1 ? 24'hFFFFFF : {16'h0000, r_b1};
      {r_hs2, r_vs2, r_bl2} <= {r_hs1, r_vs1, r_bl1};
    end
  end
  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign vga_hs      = r_hs2;
  assign vga_vs      = r_vs2;
  assign vga_blank_n = r_bl2;
  assign frame_count = r_frame_count;
endmodule
